data_memory_sized: RTL

Parametrised successor to the single-port data memory of the MIPS datapath. It adds byte, halfword and word accesses with little-endian lane steering and sign/zero extension of loads. It also adds base-address translation, alignment and range checking, and a req/ack handshake with a configurable number of wait states. It sits between the MEM stage (or a stall-capable controller) and the RAM array, replacing the always-ready word memory.

---
 rtl/data_memory_sized_if.sv | 26 ++
 rtl/data_memory_sized.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/data_memory_sized_if.sv
// Request/response bus between the MEM stage (master) and data_memory_sized (slave).
interface data_memory_sized_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic                  req;
  logic                  mem_write;
  logic [1:0]            size;
  logic                  unsigned_load;
  logic [31:0]           address;
  logic [DATA_WIDTH-1:0] write_data;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  ack;
  logic                  busy;
  logic                  misaligned;
  logic                  out_of_range;

  modport master (
    output req, mem_write, size, unsigned_load, address, write_data,
    input  read_data, ack, busy, misaligned, out_of_range
  );

  modport slave (
    input  req, mem_write, size, unsigned_load, address, write_data,
    output read_data, ack, busy, misaligned, out_of_range
  );
endinterface

// File: rtl/data_memory_sized.sv
// Byte/half/word data memory with base translation, alignment/range checks and
// a req/ack handshake that inserts WAIT_STATES cycles before completion.
module data_memory_sized #(
  parameter int          DATA_WIDTH   = 32,
  parameter int          MEMORY_DEPTH = 1024,
  parameter logic [31:0] BASE_ADDR    = 32'h1001_0000,
  parameter int          WAIT_STATES  = 1
) (
  input  logic               clk,
  input  logic               reset,
  data_memory_sized_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  localparam int          AW      = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
  localparam logic [32:0] LIMIT   = 33'(MEMORY_DEPTH) << 2;
  localparam logic [3:0]  WS_LAST = 4'(WAIT_STATES - 1);

  state_t                state_q;
  logic [3:0]            cnt_q;
  logic                  ack_q, busy_q, mis_q, oor_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  write_q, uns_q;
  logic [1:0]            size_q;
  logic [31:0]           addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic [DATA_WIDTH-1:0] mem_q [MEMORY_DEPTH];

  logic                  cur_write, cur_uns;
  logic [1:0]            cur_size;
  logic [31:0]           cur_addr, offset;
  logic [DATA_WIDTH-1:0] cur_wdata, rword, load_val, wlane;
  logic [7:0]            byte_v;
  logic [15:0]           half_v;
  logic [3:0]            be;
  logic [AW-1:0]         idx;
  logic                  mis, oor, enter_done, mem_we;

  // With zero wait states the access completes on the accept edge itself, so
  // the datapath must see the live bus fields rather than the latched copy.
  always_comb begin
    cur_write = write_q;
    cur_uns   = uns_q;
    cur_size  = size_q;
    cur_addr  = addr_q;
    cur_wdata = wdata_q;
    if (state_q == S_IDLE) begin
      cur_write = bus.mem_write;
      cur_uns   = bus.unsigned_load;
      cur_size  = bus.size;
      cur_addr  = bus.address;
      cur_wdata = bus.write_data;
    end
  end

  assign offset = cur_addr - BASE_ADDR;
  assign oor    = ({1'b0, offset} >= LIMIT);
  assign idx    = offset[AW+1:2];

  always_comb begin
    case (cur_size)
      2'b00:   mis = 1'b0;
      2'b01:   mis = cur_addr[0];
      2'b10:   mis = (cur_addr[1:0] != 2'b00);
      default: mis = 1'b1;
    endcase
  end

  assign enter_done = reset &&
                      (((state_q == S_IDLE) && bus.req && (WAIT_STATES == 0)) ||
                       ((state_q == S_WAIT) && (cnt_q == WS_LAST)));
  assign mem_we     = enter_done && cur_write && !mis && !oor;

  // NOTE: every variable assigned here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    be    = '0;
    wlane = '0;
    case (cur_size)
      2'b00: begin
        be    = 4'b0001 << cur_addr[1:0];
        wlane = {4{cur_wdata[7:0]}};
      end
      2'b01: begin
        be    = cur_addr[1] ? 4'b1100 : 4'b0011;
        wlane = {2{cur_wdata[15:0]}};
      end
      2'b10: begin
        be    = 4'b1111;
        wlane = cur_wdata;
      end
      default: ;
    endcase
  end

  assign rword = mem_q[idx];

  always_comb begin
    byte_v   = rword[{cur_addr[1:0], 3'b000} +: 8];
    half_v   = rword[{cur_addr[1], 4'b0000} +: 16];
    load_val = '0;
    case (cur_size)
      2'b00:   load_val = {{24{~cur_uns & byte_v[7]}}, byte_v};
      2'b01:   load_val = {{16{~cur_uns & half_v[15]}}, half_v};
      2'b10:   load_val = rword;
      default: load_val = '0;
    endcase
  end

  // NOTE: the array and the request latch are plain datapath storage with no
  // reset; only control state is reset, and a reset on the DONE-entry edge
  // suppresses the write through mem_we.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[idx][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && bus.req) begin
      write_q <= bus.mem_write;
      size_q  <= bus.size;
      uns_q   <= bus.unsigned_load;
      addr_q  <= bus.address;
      wdata_q <= bus.write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      mis_q   <= 1'b0;
      oor_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.req) begin
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= (WAIT_STATES == 0) ? S_DONE : S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q == WS_LAST) state_q <= S_DONE;
          else                  cnt_q   <= cnt_q + 4'd1;
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
      if (enter_done) begin
        ack_q   <= 1'b1;
        mis_q   <= mis;
        oor_q   <= oor;
        rdata_q <= (mis || oor || cur_write) ? '0 : load_val;
      end
    end
  end

  assign bus.read_data    = rdata_q;
  assign bus.ack          = ack_q;
  assign bus.busy         = busy_q;
  assign bus.misaligned   = mis_q;
  assign bus.out_of_range = oor_q;

endmodule
